// File: rtl/sqrt_pkg.sv
// Shared types for the square-root dispatcher: FSM states, core mode codes
// and the queued operand layout {mode, data}.
package sqrt_pkg;

  localparam int DATA_W = 16;
  localparam int OPND_W = DATA_W + 1;

  localparam logic [2:0] MODE_PAPER   = 3'd0;
  localparam logic [2:0] MODE_RESTORE = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic              mode;
    logic [DATA_W-1:0] data;
  } operand_t;

  // Map the one-bit stream mode onto the core's three-bit algorithm select.
  function automatic logic [2:0] core_mode_of(input logic mode);
    return mode ? MODE_RESTORE : MODE_PAPER;
  endfunction

endpackage

// File: rtl/sqrt_fifo.sv
// Operand queue: DEPTH entries (power of two), pointers carry one extra bit
// so that full and empty are told apart. Head is read combinationally so the
// dispatcher can load it into its operand register on the pop edge.
module sqrt_fifo
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = OPND_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array: written on an accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Pointer update; push and pop in the same cycle both advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sqrt_dispatch.sv
// Square-root dispatcher: queues operands, feeds them one at a time to an
// external square-root core and presents results on a valid/ready stream.
// Optional build macro SQRT_DISPATCH_TIMEOUT_EN adds a WAIT-state watchdog
// that aborts a core run after TIMEOUT_CYCLES and pulses err_timeout.
module sqrt_dispatch
  import sqrt_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              core_start,
  output logic [DATA_W-1:0] core_data,
  output logic [2:0]        core_mode,
  input  logic [DATA_W-1:0] core_root,
  input  logic [DATA_W-1:0] core_rem,
  input  logic              core_finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_root,
  output logic [DATA_W-1:0] out_rem,
  output logic              out_mode,
  output logic              busy,
  output logic              err_timeout
);

  state_e            r_state;
  state_e            w_state_next;
  operand_t          r_operand;
  operand_t          w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_capture;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_root;
  logic [DATA_W-1:0] r_out_rem;
  logic              r_out_mode;

  sqrt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OPND_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_data  ({in_mode, in_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign in_ready = !w_fifo_full;

`ifdef SQRT_DISPATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_timeout;
  logic            w_timeout_hit;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control: issue only while the output slot is empty, and
  // only listen to core_finish once the core has actually been started.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
`ifdef SQRT_DISPATCH_TIMEOUT_EN
    w_timeout_hit = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !r_out_valid) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_finish) begin
          w_capture    = 1'b1;
          w_state_next = ST_IDLE;
        end
`ifdef SQRT_DISPATCH_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          w_timeout_hit = 1'b1;
          w_state_next  = ST_IDLE;
        end
`endif
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand register: loaded on pop and held for the whole core run, since
  // the core reads core_data/core_mode combinationally until it finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand <= '0;
    end else if (w_pop) begin
      r_operand <= w_head;
    end
  end

  // Result register: capture on finish, hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_root  <= '0;
      r_out_rem   <= '0;
      r_out_mode  <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_root  <= core_root;
      r_out_rem   <= core_rem;
      r_out_mode  <= r_operand.mode;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef SQRT_DISPATCH_TIMEOUT_EN
  // Watchdog: counts cycles spent in WAIT; the abort pulse lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout_hit;
      if (r_state == ST_WAIT) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

  assign core_start = (r_state == ST_START);
  assign core_data  = r_operand.data;
  assign core_mode  = core_mode_of(r_operand.mode);
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = r_out_valid;
  assign out_root   = r_out_root;
  assign out_rem    = r_out_rem;
  assign out_mode   = r_out_mode;

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Directed bench for sqrt_dispatch with a behavioural square-root core.
// Build with SQRT_DISPATCH_TIMEOUT_EN defined to also exercise the watchdog.
module tb_sqrt_dispatch;

  localparam int TB_DEPTH   = 4;
  localparam int TB_TIMEOUT = 31;
  localparam int CORE_LAT   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        core_start;
  logic [15:0] core_data;
  logic [2:0]  core_mode;
  logic [15:0] core_root;
  logic [15:0] core_rem;
  logic        core_finish;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_root;
  logic [15:0] out_rem;
  logic        out_mode;
  logic        busy;
  logic        err_timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sqrt_dispatch #(
    .FIFO_DEPTH     (TB_DEPTH),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_mode   (core_mode),
    .core_root   (core_root),
    .core_rem    (core_rem),
    .core_finish (core_finish),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_root    (out_root),
    .out_rem     (out_rem),
    .out_mode    (out_mode),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // ---------------- behavioural core ----------------
  logic        hang = 1'b0;
  logic        spurious = 1'b0;
  logic        model_finish;
  logic [2:0]  model_cnt;
  logic [15:0] model_root;
  logic [15:0] model_rem;

  assign core_finish = model_finish | spurious;
  assign core_root   = model_root;
  assign core_rem    = model_rem;

  // Returns {root, remainder}; mode 1 treats data as a 0.16 fraction.
  function automatic logic [31:0] core_calc(input logic [2:0] m, input logic [15:0] d);
    logic [31:0] x;
    logic [31:0] r;
    logic [31:0] t;
    logic [31:0] rm;
    x = m[0] ? {d, 16'h0000} : {16'h0000, d};
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= x) r = t;
    end
    rm = x - r * r;
    return {r[15:0], rm[15:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_cnt    <= '0;
      model_finish <= 1'b0;
      model_root   <= '0;
      model_rem    <= '0;
    end else begin
      model_finish <= 1'b0;
      if (core_start) begin
        model_cnt <= 3'(CORE_LAT);
      end else if (model_cnt != 0) begin
        model_cnt <= model_cnt - 3'd1;
        if (model_cnt == 3'd1 && !hang) begin
          model_finish <= 1'b1;
          {model_root, model_rem} <= core_calc(core_mode, core_data);
        end
      end
    end
  end

  // Operand stability monitor: counts WAIT cycles where core_data/core_mode
  // drift from the value presented with core_start.
  logic [15:0] mon_data = '0;
  logic [2:0]  mon_mode = '0;
  int          stab_viol = 0;
  int          stab_samples = 0;

  always @(negedge clk) begin
    if (core_start) begin
      mon_data = core_data;
      mon_mode = core_mode;
    end else if (busy) begin
      stab_samples++;
      if (core_data !== mon_data || core_mode !== mon_mode) stab_viol++;
    end
  end

  // ---------------- helpers ----------------
  logic [15:0] res_root [8];
  logic [15:0] res_rem [8];
  logic        res_mode [8];
  logic        res_busy_after [8];

  task automatic push(input logic m, input logic [15:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Gathers up to n results (out_ready must be high) and, for each, the busy
  // flag in the cycle after it was taken.
  task automatic collect(input int n, input int budget, output int got);
    int  cyc;
    logic prev;
    got  = 0;
    cyc  = 0;
    prev = 1'b0;
    while (cyc < budget) begin
      if (prev) begin
        res_busy_after[got-1] = busy;
        prev = 1'b0;
        if (got == n) break;
      end
      if (out_valid && got < n) begin
        res_root[got] = out_root;
        res_rem[got]  = out_rem;
        res_mode[got] = out_mode;
        $display("result %0d: root=%0d rem=%0d mode=%0d", got, out_root, out_rem, out_mode);
        got++;
        prev = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0 || core_start !== 1'b0) begin failures++; $display("FAIL reset_busy_start got=%b%b exp=00", busy, core_start); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    checks++; if (out_root !== 16'd0 || out_rem !== 16'd0 || core_data !== 16'd0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", out_root, out_rem, core_data); end
  endtask

  task automatic test_single();
    int n_edge;
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 16'd144;
    @(posedge clk); #1;                       // E0: push
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || core_start !== 1'b0) begin failures++; $display("FAIL single_e0 busy/start got=%b%b exp=00", busy, core_start); end
    @(posedge clk); #1;                       // E1: pop
    checks++; if (core_start !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_e1 start/busy got=%b%b exp=11", core_start, busy); end
    checks++; if (core_data !== 16'd144 || core_mode !== 3'd0) begin failures++; $display("FAIL single_core_in got=%0d/%0d exp=144/0", core_data, core_mode); end
    @(posedge clk); #1;                       // E2
    checks++; if (core_start !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_e2 start/busy got=%b%b exp=01", core_start, busy); end
    n_edge = 2;
    while (!out_valid && n_edge < 40) begin
      @(posedge clk); #1;
      n_edge++;
    end
    checks++; if (n_edge !== 7) begin failures++; $display("FAIL single_latency got=%0d exp=7", n_edge); end
    $display("single: root=%0d rem=%0d mode=%0d", out_root, out_rem, out_mode);
    checks++; if (out_valid !== 1'b1 || out_root !== 16'd12 || out_rem !== 16'd0 || out_mode !== 1'b0) begin
      failures++; $display("FAIL single_result got=%b/%0d/%0d/%0d exp=1/12/0/0", out_valid, out_root, out_rem, out_mode); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_drain valid/busy got=%b%b exp=00", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int got;
    int viol0;
    int samp0;
    viol0 = stab_viol;
    samp0 = stab_samples;
    out_ready = 1'b1;
    push(1'b0, 16'd200);
    push(1'b1, 16'h4000);
    collect(2, 100, got);
    checks++; if (got !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", got); end
    checks++; if (res_root[0] !== 16'd14 || res_rem[0] !== 16'd4 || res_mode[0] !== 1'b0) begin
      failures++; $display("FAIL b2b_first got=%0d/%0d/%0d exp=14/4/0", res_root[0], res_rem[0], res_mode[0]); end
    checks++; if (res_root[1] !== 16'h8000 || res_rem[1] !== 16'd0 || res_mode[1] !== 1'b1) begin
      failures++; $display("FAIL b2b_second got=%h/%0d/%0d exp=8000/0/1", res_root[1], res_rem[1], res_mode[1]); end
    checks++; if (res_busy_after[0] !== 1'b0) begin failures++; $display("FAIL b2b_issue_gap busy got=%b exp=0", res_busy_after[0]); end
    checks++; if (stab_viol !== viol0 || stab_samples <= samp0) begin
      failures++; $display("FAIL b2b_core_stable viol got=%0d exp=%0d samples=%0d", stab_viol - viol0, 0, stab_samples - samp0); end
    checks++; if (mon_mode !== 3'd1) begin failures++; $display("FAIL b2b_core_mode got=%0d exp=1", mon_mode); end
  endtask

  task automatic test_full();
    logic [15:0] vals [6]  = '{16'd1, 16'd10, 16'd49, 16'd65535, 16'd0, 16'd99};
    logic [15:0] roots [5] = '{16'd1, 16'd3, 16'd7, 16'd255, 16'd0};
    logic [15:0] rems [5]  = '{16'd0, 16'd1, 16'd0, 16'd510, 16'd0};
    logic [5:0]  rdy;
    logic [15:0] held_root;
    logic [15:0] held_rem;
    int acc;
    int cyc;
    int got;
    int extra;
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_mode = 1'b0; in_data = vals[i];
      rdy[i] = in_ready;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (acc !== 5) begin failures++; $display("FAIL full_accepted got=%0d exp=5", acc); end
    checks++; if (rdy !== 6'b011111) begin failures++; $display("FAIL full_in_ready got=%b exp=011111", rdy); end
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (out_valid !== 1'b1 || out_root !== 16'd1) begin failures++; $display("FAIL full_first valid/root got=%b/%0d exp=1/1", out_valid, out_root); end
    held_root = out_root;
    held_rem  = out_rem;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_root !== held_root || out_rem !== held_rem || busy !== 1'b0) begin
      failures++; $display("FAIL full_hold got=%b/%0d/%0d busy=%b exp=1/%0d/%0d busy=0", out_valid, out_root, out_rem, busy, held_root, held_rem); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_still_full in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    collect(5, 200, got);
    checks++; if (got !== 5) begin failures++; $display("FAIL full_count got=%0d exp=5", got); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_root[i] !== roots[i] || res_rem[i] !== rems[i] || res_mode[i] !== 1'b0 || res_busy_after[i] !== 1'b0) begin
        failures++; $display("FAIL full_result%0d got=%0d/%0d/%0d busy=%b exp=%0d/%0d/0 busy=0",
                             i, res_root[i], res_rem[i], res_mode[i], res_busy_after[i], roots[i], rems[i]);
      end
    end
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || busy) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL full_no_sixth got=%0d exp=0", extra); end
  endtask

  task automatic test_spurious_finish();
    int got;
    out_ready = 1'b1;
    spurious = 1'b1;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 16'd81;
    @(posedge clk); #1;                       // E0 (IDLE, finish high)
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL spur_idle out_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;                       // E1 (pop, START with finish high)
    checks++; if (out_valid !== 1'b0 || core_start !== 1'b1) begin failures++; $display("FAIL spur_pop valid/start got=%b%b exp=01", out_valid, core_start); end
    @(posedge clk); #1;                       // E2 (START must ignore finish)
    spurious = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL spur_start valid/busy got=%b%b exp=01", out_valid, busy); end
    collect(1, 40, got);
    checks++; if (got !== 1 || res_root[0] !== 16'd9 || res_rem[0] !== 16'd0) begin
      failures++; $display("FAIL spur_result got=%0d:%0d/%0d exp=1:9/0", got, res_root[0], res_rem[0]); end
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    int got;
    out_ready = 1'b1;
    push(1'b0, 16'd225);
    push(1'b0, 16'd4);
    push(1'b1, 16'd9);
    push(1'b0, 16'd16);
    checks++; if (busy !== 1'b1 || core_start !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_pre_wait busy/start/rdy got=%b%b%b exp=101", busy, core_start, in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || core_start !== 1'b0 || out_valid !== 1'b0 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL rst_async_ctl busy/start/valid/err got=%b%b%b%b exp=0000", busy, core_start, out_valid, err_timeout); end
    checks++; if (out_root !== 16'd0 || out_rem !== 16'd0 || out_mode !== 1'b0 || core_data !== 16'd0 || core_mode !== 3'd0) begin
      failures++; $display("FAIL rst_async_data got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0", out_root, out_rem, out_mode, core_data, core_mode); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_fifo_empty in_ready got=%b exp=1", in_ready); end
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rst_discard activity got=%0d exp=0", bad); end
    push(1'b0, 16'd225);
    collect(1, 40, got);
    checks++; if (got !== 1 || res_root[0] !== 16'd15 || res_rem[0] !== 16'd0) begin
      failures++; $display("FAIL rst_after_push got=%0d:%0d/%0d exp=1:15/0", got, res_root[0], res_rem[0]); end
  endtask

`ifdef SQRT_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    int at;
    int pulses;
    int ov;
    int got;
    out_ready = 1'b1;
    hang = 1'b1;
    push(1'b0, 16'd100);                      // E0
    push(1'b0, 16'd121);                      // E1 (first op popped)
    @(posedge clk); #1;                       // E2: WAIT entered
    at = -1; pulses = 0; ov = 0;
    for (k = 1; k <= TB_TIMEOUT + 3; k++) begin
      @(posedge clk); #1;
      if (err_timeout) begin
        pulses++;
        if (at < 0) at = k;
        hang = 1'b0;
      end
      if (out_valid && at < 0) ov++;
    end
    hang = 1'b0;
    checks++; if (at !== TB_TIMEOUT) begin failures++; $display("FAIL timeout_when got=%0d exp=%0d", at, TB_TIMEOUT); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
    checks++; if (ov !== 0) begin failures++; $display("FAIL timeout_no_output got=%0d exp=0", ov); end
    collect(1, 40, got);
    checks++; if (got !== 1 || res_root[0] !== 16'd11 || res_rem[0] !== 16'd0) begin
      failures++; $display("FAIL timeout_next got=%0d:%0d/%0d exp=1:11/0", got, res_root[0], res_rem[0]); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_spurious_finish();
    test_reset_mid_wait();
`ifdef SQRT_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "simulation watchdog");
  end

endmodule

// File: doc/sqrt_dispatch.md
SQRT_DISPATCH -- requirements
Module: sqrt_dispatch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, operand queue entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 31, max cycles from core_start to core_finish before abort.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_data input 16, in_mode input 1: operand stream (0 = pencil-and-paper, 1 = restoring fractional).
REQ-006 SHALL have ports core_start output 1, core_data output 16, core_mode output 3, core_root input 16, core_rem input 16, core_finish input 1: the square-root core connection.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_root output 16, out_rem output 16, out_mode output 1: the result stream.
REQ-008 SHALL have ports busy output 1 (core operation in flight) and err_timeout output 1 (one-cycle abort pulse).

Function
REQ-009 SHALL queue {in_mode,in_data} in a FIFO_DEPTH-entry FIFO; in_ready = !full; a push occurs on in_valid&&in_ready; there is no bypass from input to core.
REQ-010 SHALL run FSM IDLE -> START -> WAIT -> IDLE.
REQ-011 IDLE: when the FIFO is non-empty and out_valid==0, SHALL pop the head into the operand register and go to START.
REQ-012 START: SHALL drive core_start=1 for exactly one cycle, then go to WAIT.
REQ-013 SHALL hold core_data and core_mode={2'b00,operand mode} constant from START until WAIT exits, because the core samples them combinationally for its whole run.
REQ-014 WAIT: on core_finish==1, SHALL capture core_root, core_rem and the operand mode into the output register, set out_valid, and go to IDLE.
REQ-015 SHALL ignore core_finish in IDLE and START.
REQ-016 SHALL hold out_* stable while out_valid && !out_ready, and clear out_valid on out_valid&&out_ready.
REQ-017 SHALL issue no new operation while out_valid==1, including the cycle in which it is being drained; issue resumes in the following cycle.
REQ-018 Simultaneous push and pop on a non-full FIFO SHALL both take effect with the count unchanged; a push on a full FIFO SHALL not occur.
REQ-019 busy SHALL be 1 in START and WAIT, else 0.
REQ-020 Latency, empty pipeline, out_ready=1: push at edge E0, pop at E1, core_start high in cycle E1..E2, result visible one edge after core_finish is sampled high.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-022 On rst_n low, SHALL asynchronously clear: FSM to IDLE, FIFO empty, operand register 0, out_valid 0, out_root/out_rem 0, out_mode 0, core_start 0, err_timeout 0, timeout counter 0.
REQ-023 Reset during WAIT SHALL discard the in-flight operand and all queued operands; the core SHALL be reset from the same rst_n (inverted for its active-high rst).

Configuration
REQ-024 With SQRT_DISPATCH_TIMEOUT_EN defined: a counter SHALL run in WAIT; if TIMEOUT_CYCLES elapse with no core_finish, SHALL pulse err_timeout for one cycle, drop the operand with no output, and return to IDLE.
REQ-025 Without SQRT_DISPATCH_TIMEOUT_EN: err_timeout SHALL be tied 0, no counter SHALL exist, and WAIT SHALL persist until core_finish.

Structure
REQ-026 Package sqrt_pkg SHALL hold the FSM state enum, MODE_PAPER=3'd0, MODE_RESTORE=3'd1, and the 17-bit operand typedef {mode,data}.
REQ-027 The FIFO SHALL be a sub-module sqrt_fifo (parameterised depth and width); the FSM and output register stay in sqrt_dispatch.

Verification
REQ-028 Push mode0 data 16'd144, out_ready=1 -> one result: out_root=12, out_rem=0, out_mode=0.
REQ-029 Push mode0 16'd200 then mode1 16'h4000 back-to-back -> in order: (root 14, rem 4, mode 0), then (root 16'h8000, mode 1); core_data stable across each WAIT.
REQ-030 out_ready=0, push 6 operands with FIFO_DEPTH=4 -> 5 accepted (1 held in output, 4 queued), in_ready=0 on the 6th; release out_ready -> 5 results in push order.
REQ-031 With macro, core model never finishes -> err_timeout pulses once, TIMEOUT_CYCLES cycles after WAIT entry, with no out_valid; the next queued operand then issues normally.
REQ-032 Assert rst_n low mid-WAIT with 3 operands queued -> all outputs 0 immediately; after release, no result emerges until a new push.
